// File: rtl/gslcd_pkg.sv
// gslcd_pkg: pixel format encodings, bytes-per-pixel lookup and default underrun colour
package gslcd_pkg;
  typedef enum logic [1:0] {
    GSLCD_MODE_RGB888   = 2'd0,
    GSLCD_MODE_RGB565   = 2'd1,
    GSLCD_MODE_XRGB8888 = 2'd2,
    GSLCD_MODE_XRGB_ALT = 2'd3
  } gslcd_mode_e;
  localparam logic [23:0] GSLCD_UNDERRUN_COLOR = 24'hFF0000;
  function automatic logic [2:0] gslcd_bpp(input logic [1:0] m);
    return m == GSLCD_MODE_RGB888 ? 3'd3 : m == GSLCD_MODE_RGB565 ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/gslcd_byte_shift_buffer.sv
// gslcd_byte_shift_buffer: byte queue that drops consumed bytes from the bottom and appends whole words above the survivors
module gslcd_byte_shift_buffer #(
  parameter int W = 4,
  parameter int CAP = 8,
  localparam int CW = $clog2(CAP + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [2:0]    take,
  input  logic          wr,
  input  logic [8*W-1:0] wr_data,
  output logic [CW-1:0] cnt,
  output logic [31:0]   bytes
);
  localparam logic [8*CAP-1:0] WMASK = {{(8*CAP-8*W){1'b0}}, {(8*W){1'b1}}};
  logic [8*CAP-1:0] mem_q, mem_d, shifted;
  logic [CW-1:0] base;
  always_comb begin
    shifted = mem_q >> (8 * take);
    base = cnt - CW'(take);
    mem_d = wr ? (shifted & ~(WMASK << (8 * base))) | ((8*CAP)'(wr_data) << (8 * base)) : shifted;
  end
  always_ff @(posedge clk)
    if (reset || flush) begin
      cnt <= '0;
      mem_q <= '0;
    end else begin
      cnt <= cnt - CW'(take) + (wr ? CW'(W) : '0);
      mem_q <= mem_d;
    end
  assign bytes = mem_q[31:0];
endmodule

// File: rtl/gslcd_pixel_unpack.sv
// gslcd_pixel_unpack: unpacks framebuffer words into RGB888 pixels, filling underruns with a fixed colour
module gslcd_pixel_unpack
  import gslcd_pkg::*;
#(
  parameter int C_WORD_WIDTH = 32,
  parameter logic [23:0] C_UNDERRUN_COLOR = GSLCD_UNDERRUN_COLOR
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    frame_start,
  input  logic [C_WORD_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    pix_rd,
  output logic [23:0]             pix_data,
  output logic                    pix_valid,
  output logic                    pix_underrun,
  output logic [15:0]             underrun_count
);
  localparam int W = C_WORD_WIDTH / 8;
  localparam int CAP = 2 * W;
  localparam int CW = $clog2(CAP + 1);
  if (C_WORD_WIDTH != 32 && C_WORD_WIDTH != 64) begin : g_bad_width
    $error("gslcd_pixel_unpack: C_WORD_WIDTH must be 32 or 64");
  end
  logic [1:0] act_mode;
  logic [2:0] bpp, take;
  logic [CW-1:0] cnt;
  logic [31:0] b;
  logic [7:0] unused_b3;
  logic rd, has, wr;
  logic [23:0] pix;
  always_comb begin
    bpp = gslcd_bpp(act_mode);
    rd = pix_rd && !frame_start;
    has = cnt >= CW'(bpp);
    take = rd && has ? bpp : 3'd0;
    s_ready = !reset && !frame_start && (cnt - CW'(take) <= CW'(CAP - W));
    wr = s_valid && s_ready;
    pix = act_mode == GSLCD_MODE_RGB565 ? {b[15:11], b[15:13], b[10:5], b[10:9], b[4:0], b[4:2]} : b[23:0];
  end
  assign unused_b3 = b[31:24];
  gslcd_byte_shift_buffer #(.W(W), .CAP(CAP)) u_buf (
    .clk(clk),
    .reset(reset),
    .flush(frame_start),
    .take(take),
    .wr(wr),
    .wr_data(s_data),
    .cnt(cnt),
    .bytes(b)
  );
  always_ff @(posedge clk)
    if (reset) begin
      act_mode <= 2'd0;
      pix_data <= 24'd0;
      pix_valid <= 1'b0;
      pix_underrun <= 1'b0;
      underrun_count <= 16'd0;
    end else begin
      pix_valid <= rd;
      if (frame_start) begin
        act_mode <= mode;
        underrun_count <= 16'd0;
      end else if (rd && !has && underrun_count != 16'hFFFF)
        underrun_count <= underrun_count + 16'd1;
      if (rd) begin
        pix_data <= has ? pix : C_UNDERRUN_COLOR;
        pix_underrun <= !has;
      end
    end
endmodule

// File: tb/tb_gslcd_pixel_unpack.sv
// tb_gslcd_pixel_unpack: scoreboard bench for the pixel unpacker at 32- and 64-bit word widths
module tb_gslcd_pixel_unpack;
  logic clk = 0, reset = 1, frame_start = 0, s_valid = 0, pix_rd = 0, sel = 0;
  logic [1:0] mode = 2'd0;
  logic [63:0] s_data = '0;
  logic rdy32, rdy64, pv32, pv64, pu32, pu64, rdy, pv, pu;
  logic [23:0] pd32, pd64, pd;
  logic [15:0] uc32, uc64, uc;
  int total = 0, bad = 0, pv_cnt = 0, base_cnt = 0;
  logic [24:0] sb[$];
  logic [23:0] pq[$];
  logic [63:0] wq[$];
  bit uflag = 0;
  always #5 clk = ~clk;
  gslcd_pixel_unpack #(.C_WORD_WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .mode(mode), .frame_start(frame_start),
    .s_data(s_data[31:0]), .s_valid(s_valid && !sel), .s_ready(rdy32),
    .pix_rd(pix_rd), .pix_data(pd32), .pix_valid(pv32), .pix_underrun(pu32),
    .underrun_count(uc32)
  );
  gslcd_pixel_unpack #(.C_WORD_WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .mode(mode), .frame_start(frame_start),
    .s_data(s_data), .s_valid(s_valid && sel), .s_ready(rdy64),
    .pix_rd(pix_rd), .pix_data(pd64), .pix_valid(pv64), .pix_underrun(pu64),
    .underrun_count(uc64)
  );
  assign rdy = sel ? rdy64 : rdy32;
  assign pv = sel ? pv64 : pv32;
  assign pu = sel ? pu64 : pu32;
  assign pd = sel ? pd64 : pd32;
  assign uc = sel ? uc64 : uc32;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  always @(posedge clk) begin
    #2;
    if (pv) begin
      pv_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pixel got=%h", pd);
      end else
        check("pixel", {7'b0, pu, pd}, {7'b0, sb.pop_front()});
    end
  end
  task automatic step(input int n_reads, input bit tog);
    int left = n_reads;
    int cyc = 0;
    forever begin
      @(negedge clk);
      s_valid = wq.size() > 0;
      s_data = s_valid ? wq[0] : '0;
      pix_rd = left > 0;
      if (tog) mode = (left <= 400 && left > 390) ? 2'd1 : 2'd0;
      #1;
      if (n_reads == 0 && !(s_valid && rdy)) begin
        s_valid = 0;
        break;
      end
      if (s_valid && rdy) void'(wq.pop_front());
      if (pix_rd) begin
        sb.push_back(uflag ? {1'b1, 24'hFF0000} : {1'b0, pq.pop_front()});
        left--;
      end
      if (n_reads > 0 && left == 0) break;
      if (++cyc > n_reads + 100) begin
        total++;
        bad++;
        $display("FAIL step_timeout left=%0d words=%0d", left, wq.size());
        break;
      end
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 0;
      pix_rd = 0;
    end
  endtask
  task automatic frame(input logic [1:0] m, input logic s);
    @(negedge clk);
    sel = s;
    mode = m;
    frame_start = 1;
    s_valid = 0;
    pix_rd = 0;
    @(negedge clk);
    frame_start = 0;
  endtask
  initial begin
    s_valid = 1;
    pix_rd = 1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("reset_s_ready", rdy, 0);
      check("reset_pix_valid", pv, 0);
      check("reset_pix_data", pd, 0);
      check("reset_underrun_count", uc, 0);
    end
    @(negedge clk);
    reset = 0;
    s_valid = 0;
    pix_rd = 0;
    #1;
    check("release_s_ready", rdy, 1);
    frame(2'd0, 1'b0);
    wq = '{64'h44332211, 64'h88776655, 64'hCCBBAA99};
    pq = '{24'h332211, 24'h665544, 24'h998877, 24'hCCBBAA};
    step(0, 0);
    step(4, 0);
    idle(2);
    check("rgb888_underrun_count", uc, 0);
    frame(2'd1, 1'b0);
    wq = '{64'hF80007E0, 64'h0000001F};
    pq = '{24'h00FF00, 24'hFF0000, 24'h0000FF};
    step(0, 0);
    step(3, 0);
    idle(2);
    frame(2'd2, 1'b1);
    wq = '{64'h00ABCDEF_AA123456};
    pq = '{24'h123456, 24'hABCDEF};
    step(0, 0);
    step(2, 0);
    idle(2);
    frame(2'd0, 1'b0);
    uflag = 1;
    step(100, 0);
    idle(1);
    #1;
    check("underrun_count_100", uc, 100);
    step(69900, 0);
    idle(1);
    #1;
    check("underrun_count_sat", uc, 16'hFFFF);
    frame(2'd0, 1'b0);
    #1;
    check("underrun_count_cleared", uc, 0);
    uflag = 0;
    for (int i = 0; i < 620; i++) wq.push_back({32'h0, 8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    for (int j = 0; j < 800; j++) pq.push_back({8'(3*j+2), 8'(3*j+1), 8'(3*j)});
    step(0, 0);
    @(negedge clk);
    s_valid = 1;
    s_data = wq[0];
    pix_rd = 0;
    #1;
    check("full_no_read_s_ready", rdy, 0);
    pix_rd = 1;
    #1;
    check("full_read_s_ready", rdy, 0);
    pix_rd = 0;
    base_cnt = pv_cnt;
    step(800, 1);
    wq.delete();
    @(negedge clk);
    frame_start = 1;
    pix_rd = 1;
    s_valid = 0;
    mode = 2'd0;
    #1;
    check("tp_underrun_count", uc, 0);
    @(negedge clk);
    frame_start = 0;
    pix_rd = 0;
    #1;
    check("fs_rd_pix_valid", pv, 0);
    check("tp_pixels", pv_cnt - base_cnt, 800);
    uflag = 1;
    step(1, 0);
    idle(2);
    check("fs_flushed_underrun_count", uc, 1);
    uflag = 0;
    idle(2);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gslcd_pixel_unpack.md
# gslcd_pixel_unpack

Parametrised unpacker that sits between the framebuffer read FIFO and the LCD timing generator. It accepts fixed-width memory words over a valid/ready handshake and emits one 24-bit RGB888 pixel per read strobe. Pixel format is selectable per frame: packed RGB888, RGB565 or XRGB8888. Underruns are counted and replaced with a fixed colour. It generalises the fixed 32-to-24 packer to 32- or 64-bit words, multiple formats and underrun accounting.

## Interface
- C_WORD_WIDTH, 32, input word width; only 32 or 64 are legal, any other value is an elaboration error.
- C_UNDERRUN_COLOR, 24'hFF0000, pixel emitted on underrun.
- clk  in  1  single clock (LCD pixel clock domain).
- reset  in  1  **synchronous, active-high** reset.
- mode  in  2  pixel format: 0 = RGB888 packed, 1 = RGB565, 2 = XRGB8888, 3 = treated as XRGB8888. Sampled only at frame_start.
- frame_start  in  1  one-cycle pulse: flush the buffer, latch mode, clear underrun statistics.
- s_data  in  C_WORD_WIDTH  input word, little-endian byte order (byte 0 = s_data[7:0], consumed first).
- s_valid  in  1  s_data valid.
- s_ready  out  1  word accepted when s_valid && s_ready.
- pix_rd  in  1  pixel request (timing generator read-active).
- pix_data  out  24  {R[23:16], G[15:8], B[7:0]}.
- pix_valid  out  1  pix_data valid; this is pix_rd delayed by one cycle.
- pix_underrun  out  1  the pixel currently on pix_data is the underrun colour.
- underrun_count  out  16  saturating count of underrun pixels since the last frame_start.

## Operation
- Internal byte buffer:
  - W = C_WORD_WIDTH/8 bytes per word.
  - CAP = 2·W bytes of capacity.
  - cnt holds the number of valid bytes, width clog2(CAP+1).
- Bytes per pixel, from the latched mode (act_mode): bpp = 3 / 2 / 4.
- Consume this cycle: take = (pix_rd && cnt ≥ bpp && !frame_start) ? bpp : 0.
- s_ready = !reset && !frame_start && (cnt − take ≤ CAP − W).
  - This is a combinational path from pix_rd to s_ready; it is intentional.
- Next count: cnt ← cnt − take + (s_valid && s_ready ? W : 0).
  - Bytes shift down by take.
  - The new word is written starting at position cnt − take.
- Pixel decode uses buffer bytes b0..b3:
  - RGB888: R = b2, G = b1, B = b0.
  - XRGB8888: R = b2, G = b1, B = b0; b3 is discarded.
  - RGB565: v = {b1, b0}, then R = {v[15:11], v[15:13]}, G = {v[10:5], v[10:9]}, B = {v[4:0], v[4:2]} (bit replication).
- Underrun: pix_rd && cnt < bpp && !frame_start.
  - Emit C_UNDERRUN_COLOR with pix_underrun = 1.
  - No bytes are consumed.
  - underrun_count increments, saturating at 16'hFFFF.
- frame_start has priority over everything except reset:
  - cnt ← 0, buffer contents are discarded, act_mode ← mode, underrun_count ← 0.
  - A pix_rd in the same cycle is ignored: pix_valid is 0 in the next cycle and no underrun is counted.
- A change on mode in the middle of a frame has no effect until the next frame_start.

## Timing
- Reset values:
  - cnt = 0, act_mode = 0.
  - pix_data = 0, pix_valid = 0, pix_underrun = 0, underrun_count = 0.
  - s_ready = 0 while reset is high.
- Latency: pix_rd in cycle n gives pix_data, pix_valid and pix_underrun registered in cycle n+1.
- The pixel is decoded from the buffer state at cycle n; it never bypasses from the same-cycle s_data.
- When pix_valid = 0, pix_data holds its last value.
- Sustained rate is 1 pixel/cycle in every mode, provided the buffer is full when the first pix_rd arrives and s_valid stays high.
  - RGB888 at W = 4 reaches steady state with cnt cycling 8→5→6→7→8. cnt never drops below bpp.
- Boundaries:
  - cnt = CAP with no read: s_ready = 0.
  - cnt = CAP with a read: s_ready = 1 only if CAP − bpp ≤ W.
  - Simultaneous accept and consume is always legal.
  - reset asserted mid-frame: returns to the reset values on the next edge.

## Structure
- Package gslcd_pkg holds:
  - mode encodings (GSLCD_MODE_RGB888/RGB565/XRGB8888);
  - function gslcd_bpp(mode);
  - the default underrun colour constant.
- Sub-module gslcd_byte_shift_buffer (parameters W and CAP) owns the byte array, cnt, the shift and append logic, and exposes bytes 0..3.
- Format decode and underrun accounting stay in gslcd_pixel_unpack.

## Test plan
- **Reset:** hold reset for 3 cycles with s_valid = 1 and pix_rd = 1 → s_ready = 0, pix_valid = 0, pix_data = 0, underrun_count = 0. In the first cycle after release, s_ready = 1.
- **RGB888, W = 32:**
  - Stimulus: frame_start with mode = 0; words 0x44332211, 0x88776655, 0xCCBBAA99; then 4 pix_rd.
  - Required: pix_data 0x332211, 0x665544, 0x998877, 0xCCBBAA, all with pix_underrun = 0.
- **RGB565:**
  - Stimulus: mode = 1; words 0xF80007E0, 0x0000001F; then 3 pix_rd.
  - Required: pix_data 0x00FF00, 0xFF0000, 0x0000FF.
- **XRGB8888, W = 64:**
  - Stimulus: mode = 2; word 0x00ABCDEF_AA123456; then 2 pix_rd.
  - Required: pix_data 0x123456, 0xABCDEF.
- **Underrun:**
  - Stimulus: frame_start, then 70000 pix_rd with s_valid = 0.
  - Required: every pixel is 0xFF0000 with pix_underrun = 1, and underrun_count saturates at 0xFFFF.
  - A following frame_start clears underrun_count to 0.
- **Throughput, frame_start priority and mode latch:**
  - Stimulus: RGB888 with W = 32; prime the buffer to CAP; hold s_valid = 1 and pix_rd = 1 for 800 cycles.
  - Required: 800 valid pixels and underrun_count = 0.
  - Toggling mode mid-stream changes nothing.
  - frame_start asserted together with pix_rd gives pix_valid = 0 next cycle and cnt = 0.
